ntt_bitrev_perm_ctrl: RTL

Sequencer that performs an in-place bit-reversal permutation of a coefficient array of N = 2^nof_bits 32-bit words (nof_bits 6..12), ahead of or after an NTT in the PQ datapath.
- Scans indices i = 0..N-1 and computes j = bitrev_nof_bits(i).
- For every i < j, swaps mem[i] and mem[j] through a single-port request/grant memory interface.
- Sits between the PQ control logic and the coefficient scratchpad.

---
 rtl/ntt_bitrev_perm_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ntt_bitrev_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ntt_bitrev_perm_ctrl
// Description : In-place bit-reversal permutation sequencer for an NTT
//               coefficient array of N = 2^nof_bits words (nof_bits 6..12).
//               Scans i = 0..N-1, computes j = bitrev(i) and swaps mem[i] and
//               mem[j] whenever i < j. It uses a single-port req/gnt memory
//               with a separate rvalid read-data return.
// Ports       : clk_i, rst_ni       - clock, asynchronous active-low reset
//               start_i             - start request, sampled only in IDLE
//               nof_bits_i          - log2(N), legal 6..12
//               base_addr_i         - byte address of coefficient 0
//               busy_o              - operation in progress
//               done_o, err_o       - one-cycle completion / illegal-size pulse
//               mem_req_o/we_o/addr_o/wdata_o - memory request channel
//               mem_gnt_i           - request accepted this cycle
//               mem_rvalid_i/rdata_i - read data return
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_bitrev_perm_ctrl #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [3:0]           nof_bits_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SCAN   = 4'd1;
  localparam logic [3:0] S_RD_I   = 4'd2;
  localparam logic [3:0] S_WAIT_I = 4'd3;
  localparam logic [3:0] S_RD_J   = 4'd4;
  localparam logic [3:0] S_WAIT_J = 4'd5;
  localparam logic [3:0] S_WR_I   = 4'd6;
  localparam logic [3:0] S_WR_J   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]           state_q, state_d;
  logic [11:0]          idx_q, idx_d;
  logic [3:0]           nof_q, nof_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] data_i_q, data_i_d;
  logic [DataWidth-1:0] data_j_q, data_j_d;

  logic [11:0]          w_rev;
  logic [3:0]           w_shamt;
  logic [11:0]          w_j;
  logic [12:0]          w_pow;
  logic [11:0]          w_last;
  logic                 w_is_last;
  logic                 w_do_swap;
  logic                 w_legal;
  logic [AddrWidth-1:0] w_addr_i;
  logic [AddrWidth-1:0] w_addr_j;

  // Full 12-bit reversal; since i < N the low (12-nof) bits of the reversed
  // value are zero, so shifting right by (12-nof) yields bitrev over nof bits.
  genvar b;
  generate
    for (b = 0; b < 12; b++) begin : g_rev
      assign w_rev[b] = idx_q[11-b];
    end
  endgenerate

  assign w_shamt   = 4'(4'd12 - nof_q);
  assign w_j       = w_rev >> w_shamt;
  // Low 12 bits of (1<<12) are zero, so the subtraction still gives 0xFFF.
  assign w_pow     = 13'd1 << nof_q;
  assign w_last    = w_pow[11:0] - 12'd1;
  assign w_is_last = (idx_q == w_last);
  assign w_do_swap = (idx_q < w_j);
  assign w_legal   = (nof_bits_i >= 4'd6) && (nof_bits_i <= 4'd12);

  assign w_addr_i  = base_q + AddrWidth'({idx_q, 2'b00});
  assign w_addr_j  = base_q + AddrWidth'({w_j, 2'b00});

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nof_q    <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
      data_i_q <= '0;
      data_j_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nof_q    <= nof_d;
      base_q   <= base_d;
      err_q    <= err_d;
      data_i_q <= data_i_d;
      data_j_q <= data_j_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nof_d    = nof_q;
    base_d   = base_q;
    err_d    = err_q;
    data_i_d = data_i_q;
    data_j_d = data_j_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nof_d  = nof_bits_i;
          base_d = base_addr_i;
          idx_d  = '0;
          err_d  = !w_legal;
          state_d = w_legal ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (w_do_swap) begin
          state_d = S_RD_I;
        end else if (w_is_last) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 12'd1;
        end
      end
      S_RD_I: if (mem_gnt_i) state_d = S_WAIT_I;
      S_WAIT_I: begin
        if (mem_rvalid_i) begin
          data_i_d = mem_rdata_i;
          state_d  = S_RD_J;
        end
      end
      S_RD_J: if (mem_gnt_i) state_d = S_WAIT_J;
      S_WAIT_J: begin
        if (mem_rvalid_i) begin
          data_j_d = mem_rdata_i;
          state_d  = S_WR_I;
        end
      end
      S_WR_I: if (mem_gnt_i) state_d = S_WR_J;
      S_WR_J: begin
        if (mem_gnt_i) begin
          if (w_is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 12'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (Moore); request fields depend only on state and held
  // registers, so they stay stable while a request waits for its grant.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      S_IDLE: ;
      S_SCAN, S_WAIT_I, S_WAIT_J: busy_o = 1'b1;
      S_RD_I: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = w_addr_i;
      end
      S_RD_J: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = w_addr_j;
      end
      S_WR_I: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_addr_i;
        mem_wdata_o = data_j_q;
      end
      S_WR_J: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_addr_j;
        mem_wdata_o = data_i_q;
      end
      S_DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
